// File: rtl/mips_fetch_pkg.sv
// Shared state encodings and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with flush; head is read combinationally.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: fetch PC, imem req/gnt/rvalid, prefetch queue to decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
//
// state | meaning
// IDLE  | one cycle after reset, no requests, responses ignored
// RUN   | fetching; requests issued while credits remain
// DRAIN | discarding responses still in flight from before a redirect
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = INST_W + ADDR_W;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] redirect_aligned;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     out_cnt;
    logic [CW-1:0]     q_cnt;
    logic [CW:0]       credit_used;
    logic [CW:0]       out_after;
    logic              gnt_fire;
    logic              rsp_run;
    logic              rsp_drain;
    logic              flush;
    logic              bypass_hit;
    logic              bypass_take;
    logic              q_push;
    logic              q_pop;
    logic              a_full;
    logic              a_empty;
    logic              q_full;
    logic              q_empty;
    logic [ADDR_W-1:0] a_head;
    logic [QW-1:0]     q_head;
    logic              unused_bits;

    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign credit_used      = {1'b0, out_cnt} + {1'b0, q_cnt};
    assign imem_req         = (state == RUN) && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr        = fetch_pc;
    assign gnt_fire         = imem_req && imem_gnt;
    assign rsp_run          = (state == RUN) && imem_rvalid;
    assign rsp_drain        = (state == DRAIN) && imem_rvalid;
    assign flush            = redirect && (state != IDLE);
    // In-flight count once this cycle's grant and response are accounted for.
    assign out_after        = {1'b0, out_cnt} + (CW+1)'(gnt_fire) - (CW+1)'(rsp_run);

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = (state == RUN) && !redirect && q_empty && imem_rvalid;
`else
    assign bypass_hit = 1'b0;
`endif
    assign bypass_take = bypass_hit && inst_ready;
    assign q_push      = rsp_run && !redirect && !bypass_take;
    assign q_pop       = (state == RUN) && inst_ready && !redirect && !q_empty;

    assign inst_valid = (state == RUN) && !redirect && (!q_empty || bypass_hit);
    assign inst       = bypass_hit ? imem_rdata : q_head[QW-1:ADDR_W];
    assign inst_pc    = bypass_hit ? a_head : q_head[ADDR_W-1:0];

    assign unused_bits = ^{a_full, a_empty, q_full, redirect_pc[1:0], out_after[CW]};

    // Addresses of granted requests, consumed in order as responses return.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (gnt_fire && !redirect),
        .push_data (fetch_pc),
        .pop       (rsp_run),
        .flush     (flush),
        .head_data (a_head),
        .count     (out_cnt),
        .full      (a_full),
        .empty     (a_empty)
    );

    fetch_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data ({imem_rdata, a_head}),
        .pop       (q_pop),
        .flush     (flush),
        .head_data (q_head),
        .count     (q_cnt),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (redirect && (out_after != '0)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid && (drop_cnt == CW'(1))) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A grant in the redirect cycle belongs to the old stream and must not advance the new PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            if (flush) begin
                fetch_pc <= redirect_aligned;
            end else if (gnt_fire) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
            end
            if ((state == RUN) && redirect) begin
                drop_cnt <= out_after[CW-1:0];
            end else if (rsp_drain && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

endmodule
